mem_int_ctrl: RTL
=================

# mem_int_ctrl

Interrupt controller and CSR holder in the MEM stage of the interrupt pipeline.
- Consumes the interrupt/CSR control fields leaving the EX/MEM pipeline register and owns the IE and EPC state.
- Captures rising edges on three external request lines, tracks pending and in-service sources with priority nesting, and raises an injection request to the front end with the handler vector.
- Tracks each injected interrupt until its Int_Enter marker retires in MEM.

## Interface
Parameters:
- WIDTH, 32, datapath/PC width
- VEC_BASE, 32'h0000_0100, handler address of source 0
- VEC_STRIDE, 32'h0000_0040, address step between source handlers

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- en  in  1  MEM stage advance; CSR/in-service/pending-clear updates only when 1
- int_raw  in  3  external request lines, synchronous to clk, bit 2 highest priority
- Int_Enter  in  1  injected interrupt marker retiring in MEM
- IRS  in  3  one-hot source carried with Int_Enter
- uret  in  1  uret retiring in MEM
- IEWrite, IEWriteData  in  1, 1  csr write to IE
- EPCWrite  in  1  csr write to EPC
- EPCWriteData  in  WIDTH  EPC write value; interrupted PC when Int_Enter
- int_ack  in  1  front end accepted the injection this cycle
- int_cancel  in  1  injected marker flushed before reaching MEM
- IE  out  1  global interrupt enable
- EPC  out  WIDTH  exception PC
- int_req  out  1  injection request
- int_src  out  3  one-hot source being requested
- int_vector  out  WIDTH  handler address for int_src
- pending  out  3  latched requests
- in_service  out  3  sources currently being serviced

## Operation
- Edge capture:
  - int_raw is registered into int_prev every cycle, independent of en.
  - An edge on bit i (int_raw[i] & ~int_prev[i]) sets pending[i].
- Pending clear: Int_Enter & en clears pending at IRS. If an edge and the clear hit the same bit in the same cycle, the set wins.
- Priority:
  - top_pend = highest set bit of pending.
  - top_srv = highest set bit of in_service, or none.
- Eligibility: IE=1, state IDLE, pending≠0, and top_pend > top_srv (with INT_NEST_EN).
- Injection FSM, states IDLE and INFLIGHT:
  - IDLE: int_req = eligibility. int_ack latches int_src into hold_src and moves to INFLIGHT.
  - INFLIGHT: int_req=0. Int_Enter & en, or int_cancel, returns to IDLE. If both arrive together, Int_Enter wins.
  - int_ack while int_req=0 is ignored.
- CSR updates, each gated by en:
  - Int_Enter: IE←0; EPC←EPCWriteData; in_service[IRS]←1.
  - uret: IE←1; clear the highest set in_service bit. uret with in_service=0 changes only IE.
  - IEWrite: IE←IEWriteData. EPCWrite: EPC←EPCWriteData.
  - Precedence when several are asserted: Int_Enter over uret over IEWrite/EPCWrite. A uret arriving together with Int_Enter is ignored.
- int_vector = VEC_BASE + idx(int_src)·VEC_STRIDE, truncated to WIDTH. It is driven even when int_req=0.
- IRS not one-hot with Int_Enter: the lowest set bit is used.

## Timing
- Reset values: IE=1, EPC=0, pending=0, in_service=0, int_prev=0, state=IDLE, int_req=0, int_src=0.
- Latency: int_raw edge at cycle t → pending set at t+1 → int_req high at t+1 (combinational from registered state).
- int_ack at t → int_req low at t+1.
- Int_Enter at t → IE, EPC and in_service visible at t+1.
- With en=0: CSRs, in_service and pending-clear hold; edge capture and the FSM's int_ack/int_cancel transitions continue.
- Reset mid-INFLIGHT: returns to IDLE, pending is lost, no stray int_req.

## Configuration
- MEM_INT_NEST_EN defined: a higher-priority pending source preempts a running handler (top_pend > top_srv).
- Undefined: eligibility additionally requires in_service=0. in_service still tracks so that uret clears it.

## Structure
- Package int_pkg holds:
  - NSRC=3
  - state enum {IDLE, INFLIGHT}
  - the function that gives the highest set bit as one-hot
  - default VEC_BASE/VEC_STRIDE
- Sub-module int_edge_latch: per-source edge detector plus pending bit with set-over-clear rule, instantiated NSRC times.

## Test plan
- Reset, then int_raw=3'b001 → pending=001 next cycle, int_req=1, int_src=001, int_vector=0x100.
- Simultaneous edges 3'b101 → int_src=100, int_vector=0x180. After int_ack: int_req=0 until Int_Enter(IRS=100) with EPCWriteData=0x40 → IE=0, EPC=0x40, in_service=100, pending=001.
- With source 0 in service and IE=1, an edge on bit 1 → int_req with int_src=010. Without MEM_INT_NEST_EN, int_req stays 0 until uret clears in_service.
- int_ack then int_cancel → IDLE, int_req reasserts next cycle for the same still-pending source.
- Same-cycle edge and Int_Enter clear on bit 2 → pending[2] remains 1. Int_Enter+IEWrite(1) → IE=0.
- rst=0 during INFLIGHT with pending=011 → all outputs at reset values the next cycle. en=0 with uret held → IE and in_service unchanged.

Source files
------------

// File: rtl/mem_int_ctrl_pkg.sv
// Shared types, constants and priority helpers for the MEM-stage interrupt controller.
package int_pkg;

  localparam int unsigned NSRC  = 3;
  localparam int unsigned IDX_W = 2;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0040;

  typedef enum logic {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } state_e;

  // Highest set bit as one-hot; zero when nothing is set.
  function automatic logic [NSRC-1:0] hi_onehot(input logic [NSRC-1:0] v);
    logic [NSRC-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Lowest set bit as one-hot; zero when nothing is set.
  function automatic logic [NSRC-1:0] lo_onehot(input logic [NSRC-1:0] v);
    logic [NSRC-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Bit index of a one-hot vector; zero vector maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NSRC-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_int_ctrl_if.sv
// Control/CSR bundle between the EX/MEM register, front end and mem_int_ctrl.
interface mem_int_ctrl_if
  import int_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic              en;
  logic [NSRC-1:0]   int_raw;
  logic              Int_Enter;
  logic [NSRC-1:0]   IRS;
  logic              uret;
  logic              IEWrite;
  logic              IEWriteData;
  logic              EPCWrite;
  logic [WIDTH-1:0]  EPCWriteData;
  logic              int_ack;
  logic              int_cancel;
  logic              IE;
  logic [WIDTH-1:0]  EPC;
  logic              int_req;
  logic [NSRC-1:0]   int_src;
  logic [WIDTH-1:0]  int_vector;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   in_service;

  modport master (
    output en, int_raw, Int_Enter, IRS, uret, IEWrite, IEWriteData,
           EPCWrite, EPCWriteData, int_ack, int_cancel,
    input  IE, EPC, int_req, int_src, int_vector, pending, in_service
  );

  modport slave (
    input  en, int_raw, Int_Enter, IRS, uret, IEWrite, IEWriteData,
           EPCWrite, EPCWriteData, int_ack, int_cancel,
    output IE, EPC, int_req, int_src, int_vector, pending, in_service
  );
endinterface

// File: rtl/mem_int_ctrl_edge_latch.sv
// Per-source rising-edge detector with a pending bit; a new edge beats a same-cycle clear.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_pending
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev    <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      r_prev    <= i_raw;
      o_pending <= (i_raw & ~r_prev) | (o_pending & ~i_clr);
    end
  end
endmodule

// File: rtl/mem_int_ctrl.sv
// MEM-stage interrupt controller: pending/in-service tracking, injection FSM, IE/EPC CSRs.
// Build option: define MEM_INT_NEST_EN to let a higher-priority source preempt a running handler.
module mem_int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(DEF_VEC_BASE),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(DEF_VEC_STRIDE)
) (
  input  logic           clk,
  input  logic           rst,
  mem_int_ctrl_if.slave  bus
);
  state_e           r_state;
  logic [NSRC-1:0]  r_hold_src;
  logic             r_ie;
  logic [WIDTH-1:0] r_epc;
  logic [NSRC-1:0]  r_in_service;

  logic             w_enter;
  logic             w_uret;
  logic [NSRC-1:0]  w_irs;
  logic [NSRC-1:0]  w_clr;
  logic [NSRC-1:0]  w_pending;
  logic [NSRC-1:0]  w_top_pend;
  logic [NSRC-1:0]  w_top_srv;
  logic             w_prio_ok;
  logic             w_req;
  logic [NSRC-1:0]  w_src;
  logic [WIDTH-1:0] w_vec;

  // Int_Enter owns the cycle; a uret alongside it is dropped.
  assign w_enter = bus.Int_Enter & bus.en;
  assign w_uret  = bus.uret & bus.en & ~bus.Int_Enter;
  assign w_irs   = lo_onehot(bus.IRS);
  assign w_clr   = w_enter ? w_irs : '0;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    int_edge_latch u_latch (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (bus.int_raw[g]),
      .i_clr    (w_clr[g]),
      .o_pending(w_pending[g])
    );
  end

  // One-hot encodings compare numerically in priority order; none-in-service is 0.
  assign w_top_pend = hi_onehot(w_pending);
  assign w_top_srv  = hi_onehot(r_in_service);
`ifdef MEM_INT_NEST_EN
  assign w_prio_ok  = (w_top_pend > w_top_srv);
`else
  assign w_prio_ok  = (w_top_pend > w_top_srv) && (r_in_service == '0);
`endif

  assign w_req = r_ie && (r_state == IDLE) && (w_pending != '0) && w_prio_ok;
  assign w_src = (r_state == IDLE) ? w_top_pend : r_hold_src;
  assign w_vec = VEC_BASE + WIDTH'(onehot_idx(w_src)) * VEC_STRIDE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_src <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.int_ack && w_req) begin
            r_state    <= INFLIGHT;
            r_hold_src <= w_src;
          end
        end
        INFLIGHT: begin
          if (w_enter || bus.int_cancel) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // CSR and in-service updates, all gated by stage advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ie         <= 1'b1;
      r_epc        <= '0;
      r_in_service <= '0;
    end else if (w_enter) begin
      r_ie         <= 1'b0;
      r_epc        <= bus.EPCWriteData;
      r_in_service <= r_in_service | w_irs;
    end else if (w_uret) begin
      r_ie         <= 1'b1;
      r_in_service <= r_in_service & ~w_top_srv;
    end else if (bus.en) begin
      if (bus.IEWrite)  r_ie  <= bus.IEWriteData;
      if (bus.EPCWrite) r_epc <= bus.EPCWriteData;
    end
  end

  assign bus.IE         = r_ie;
  assign bus.EPC        = r_epc;
  assign bus.int_req    = w_req;
  assign bus.int_src    = w_src;
  assign bus.int_vector = w_vec;
  assign bus.pending    = w_pending;
  assign bus.in_service = r_in_service;
endmodule
